// File: rtl/counter_pkg.sv
// Shared definitions for the counter programming controller: FSM encoding,
// control-word geometry and helpers to read/replace one channel's mode field.
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CTRL = 2'd1,
        ST_LOAD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] CH_CTRL    = 2'h3;
    localparam int         CTRL_W     = 24;
    localparam int         CH_STRIDE  = 8;
    localparam int         MODE_BASE0 = 1;
    localparam int         MODE_BASE1 = MODE_BASE0 + CH_STRIDE;
    localparam int         MODE_BASE2 = MODE_BASE1 + CH_STRIDE;

    // Mode field of channel ch; channel 3 has no field and reads as 0.
    function automatic logic [1:0] get_mode(input logic [CTRL_W-1:0] ctrl,
                                            input logic [1:0]        ch);
        logic [1:0] m;
        case (ch)
            2'd0:    m = ctrl[MODE_BASE0 +: 2];
            2'd1:    m = ctrl[MODE_BASE1 +: 2];
            2'd2:    m = ctrl[MODE_BASE2 +: 2];
            default: m = 2'b00;
        endcase
        return m;
    endfunction

    // Control word with only channel ch's mode field replaced.
    function automatic logic [CTRL_W-1:0] set_mode(input logic [CTRL_W-1:0] ctrl,
                                                   input logic [1:0]        ch,
                                                   input logic [1:0]        mode);
        logic [CTRL_W-1:0] r;
        r = ctrl;
        case (ch)
            2'd0:    r[MODE_BASE0 +: 2] = mode;
            2'd1:    r[MODE_BASE1 +: 2] = mode;
            2'd2:    r[MODE_BASE2 +: 2] = mode;
            default: r = ctrl;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx
);

    int   idx;
    logic found;

    // Rotating priority search starting at ptr, wrapping modulo NREQ.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/counter_prog_ctrl.sv
// Programming controller: arbitrates requesters onto the counter write port,
// issuing a control-word write only when the channel's mode actually changes,
// then the lock-value write. Keeps a shadow of the counter control word.
module counter_prog_ctrl
    import counter_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    req_ch,
    input  logic [2*NREQ-1:0]    req_mode,
    input  logic [32*NREQ-1:0]   req_val,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic                 busy,
    output logic                 counter_we,
    output logic [1:0]           counter_ch,
    output logic [31:0]          counter_val,
    output logic [CTRL_W-1:0]    ctrl_shadow
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     ptr_next;
    logic [PW-1:0]     grant_idx;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   grant_latched;
    logic [1:0]        ch_latched;
    logic [31:0]       val_latched;
    logic [1:0]        sel_ch;
    logic [1:0]        sel_mode;
    logic [31:0]       sel_val;
    logic [CTRL_W-1:0] new_ctrl;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req       (req),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Fields of the requester the arbiter currently selects, and the
    // control word that would result from applying its mode.
    always_comb begin
        sel_ch   = req_ch[{grant_idx, 1'b0} +: 2];
        sel_mode = req_mode[{grant_idx, 1'b0} +: 2];
        sel_val  = req_val[{grant_idx, 5'b0} +: 32];
        new_ctrl = set_mode(ctrl_shadow, sel_ch, sel_mode);
        ptr_next = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Sequencer FSM; every output is registered and set on entry to a state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            grant_latched <= '0;
            ch_latched    <= '0;
            val_latched   <= '0;
            done          <= '0;
            err           <= '0;
            busy          <= 1'b0;
            counter_we    <= 1'b0;
            counter_ch    <= '0;
            counter_val   <= '0;
            ctrl_shadow   <= '0;
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        grant_latched <= grant;
                        ch_latched    <= sel_ch;
                        val_latched   <= sel_val;
                        ptr           <= ptr_next;
                        busy          <= 1'b1;
                        if (sel_ch == CH_CTRL) begin
                            // Invalid channel: report without touching the counter.
                            state <= ST_DONE;
                            done  <= grant;
                            err   <= grant;
                        end else if (sel_mode != get_mode(ctrl_shadow, sel_ch)) begin
                            state       <= ST_CTRL;
                            counter_we  <= 1'b1;
                            counter_ch  <= CH_CTRL;
                            counter_val <= {8'h00, new_ctrl};
                            ctrl_shadow <= new_ctrl;
                        end else begin
                            state       <= ST_LOAD;
                            counter_we  <= 1'b1;
                            counter_ch  <= sel_ch;
                            counter_val <= sel_val;
                        end
                    end
                end
                ST_CTRL: begin
                    state       <= ST_LOAD;
                    counter_we  <= 1'b1;
                    counter_ch  <= ch_latched;
                    counter_val <= val_latched;
                end
                ST_LOAD: begin
                    state      <= ST_DONE;
                    counter_we <= 1'b0;
                    done       <= grant_latched;
                end
                default: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    counter_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_prog_ctrl.sv
// Self-checking bench for counter_prog_ctrl: reset, contention ordering,
// a table of single-request sequences, and a reset asserted mid-CTRL.
module tb_counter_prog_ctrl;

    localparam int NREQ = 3;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [2*NREQ-1:0]  req_ch;
    logic [2*NREQ-1:0]  req_mode;
    logic [32*NREQ-1:0] req_val;
    logic [NREQ-1:0]    done;
    logic [NREQ-1:0]    err;
    logic               busy;
    logic               counter_we;
    logic [1:0]         counter_ch;
    logic [31:0]        counter_val;
    logic [23:0]        ctrl_shadow;

    int checks = 0;
    int errors = 0;

    counter_prog_ctrl #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_ch      (req_ch),
        .req_mode    (req_mode),
        .req_val     (req_val),
        .done        (done),
        .err         (err),
        .busy        (busy),
        .counter_we  (counter_we),
        .counter_ch  (counter_ch),
        .counter_val (counter_val),
        .ctrl_shadow (ctrl_shadow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          r;
        logic [1:0]  ch;
        logic [1:0]  mode;
        logic [31:0] val;
        logic        exp_ctrl;
        logic [23:0] exp_ctrl_word;
        logic        exp_err;
        logic [23:0] exp_shadow;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Issue one request, drop it and scramble all inputs right after the
    // grant, then check each cycle of the sequence against the vector.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        logic [NREQ-1:0] onehot;
        onehot = NREQ'(1 << v.r);
        @(negedge clk);
        req = onehot;
        req_ch[2*v.r +: 2]    = v.ch;
        req_mode[2*v.r +: 2]  = v.mode;
        req_val[32*v.r +: 32] = v.val;
        @(posedge clk);
        lat = v.exp_err ? 1 : (v.exp_ctrl ? 3 : 2);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check({tag, "_we"}, 64'(counter_we), 64'(k < lat));
            check({tag, "_busy"}, 64'(busy), 64'd1);
            if (k < lat) begin
                if (v.exp_ctrl && k == 1) begin
                    check({tag, "_ctrl_ch"}, 64'(counter_ch), 64'd3);
                    check({tag, "_ctrl_val"}, 64'(counter_val), {40'h0, v.exp_ctrl_word});
                end else begin
                    check({tag, "_load_ch"}, 64'(counter_ch), 64'(v.ch));
                    check({tag, "_load_val"}, 64'(counter_val), 64'(v.val));
                end
            end
            check({tag, "_done"}, 64'(done), (k == lat) ? 64'(onehot) : 64'd0);
            check({tag, "_err"}, 64'(err), (k == lat && v.exp_err) ? 64'(onehot) : 64'd0);
            if (k == 1) begin
                req      = '0;
                req_ch   = 6'($urandom);
                req_mode = 6'($urandom);
                req_val  = {$urandom, $urandom, $urandom};
            end
        end
        @(negedge clk);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_done"}, 64'(done), 64'd0);
        check({tag, "_idle_we"}, 64'(counter_we), 64'd0);
        check({tag, "_shadow"}, 64'(ctrl_shadow), 64'(v.exp_shadow));
        $display("txn %s r=%0d ch=%0d mode=%0d val=%08h shadow=%06h", tag, v.r, v.ch, v.mode, v.val, ctrl_shadow);
    endtask

    initial begin
        int order[$];
        int run_we;
        vec_t rv;

        //              r  ch    mode   val            ctrl  ctrl_word   err   shadow
        vecs[0] = '{0, 2'd1, 2'd2, 32'h0000_0100, 1'b1, 24'h000400, 1'b0, 24'h000400};
        vecs[1] = '{0, 2'd1, 2'd2, 32'h0000_0100, 1'b0, 24'h000000, 1'b0, 24'h000400};
        vecs[2] = '{1, 2'd0, 2'd3, 32'hDEAD_BEEF, 1'b1, 24'h000406, 1'b0, 24'h000406};
        vecs[3] = '{2, 2'd2, 2'd1, 32'h1234_5678, 1'b1, 24'h020406, 1'b0, 24'h020406};
        vecs[4] = '{2, 2'd3, 2'd1, 32'hCAFE_0001, 1'b0, 24'h000000, 1'b1, 24'h020406};
        vecs[5] = '{1, 2'd1, 2'd0, 32'h0000_0055, 1'b1, 24'h020006, 1'b0, 24'h020006};
        vecs[6] = '{0, 2'd0, 2'd3, 32'h0000_0001, 1'b0, 24'h000000, 1'b0, 24'h020006};
        vecs[7] = '{1, 2'd2, 2'd2, 32'hA5A5_5A5A, 1'b1, 24'h040006, 1'b0, 24'h040006};

        // Reset held with every requester asserting: outputs must stay quiet.
        rst      = 1'b0;
        req      = 3'b111;
        req_ch   = {2'd2, 2'd1, 2'd0};
        req_mode = '0;
        req_val  = {32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
        repeat (3) @(negedge clk);
        check("rst_we", 64'(counter_we), 64'd0);
        check("rst_ch", 64'(counter_ch), 64'd0);
        check("rst_val", 64'(counter_val), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_shadow", 64'(ctrl_shadow), 64'd0);
        $display("txn reset held with req=111");

        // Contention: all three hold req; expect LOAD-only sequences 0,1,2,0.
        rst    = 1'b1;
        run_we = 0;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            @(negedge clk);
            if (counter_we) begin
                run_we++;
                check("cont_no_ctrl_write", 64'(counter_ch == 2'd3), 64'd0);
                check("cont_load_val", 64'(counter_val), 64'(32'hA0 + 32'(counter_ch)));
                check("cont_single_write", 64'(run_we > 1), 64'd0);
            end else begin
                run_we = 0;
            end
            if (done != '0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (done[i]) order.push_back(i);
                end
                $display("txn contention done=%b", done);
            end
        end
        req = '0;
        check("cont_done_count", 64'(order.size()), 64'd4);
        if (order.size() == 4) begin
            check("cont_order0", 64'(order[0]), 64'd0);
            check("cont_order1", 64'(order[1]), 64'd1);
            check("cont_order2", 64'(order[2]), 64'd2);
            check("cont_order3", 64'(order[3]), 64'd0);
        end
        repeat (2) @(negedge clk);
        check("cont_shadow", 64'(ctrl_shadow), 64'd0);

        // Table of single-request sequences; shadow carries between entries.
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during the CTRL cycle.
        @(negedge clk);
        req          = 3'b001;
        req_ch[1:0]  = 2'd1;
        req_mode[1:0] = 2'd1;
        req_val[31:0] = 32'h0000_0077;
        @(posedge clk);
        @(negedge clk);
        check("midrst_ctrl_we", 64'(counter_we), 64'd1);
        check("midrst_ctrl_ch", 64'(counter_ch), 64'd3);
        #2;
        rst = 1'b0;
        req = '0;
        #1;
        check("midrst_we", 64'(counter_we), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_shadow", 64'(ctrl_shadow), 64'd0);
        check("midrst_val", 64'(counter_val), 64'd0);
        $display("txn reset asserted during CTRL");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        rv = '{0, 2'd1, 2'd1, 32'h0000_0077, 1'b1, 24'h000200, 1'b0, 24'h000200};
        run_vec(rv, "restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
